sprite_rom_arbiter: RTL and testbench

//  Shares the single 16x16x12b block-sprite ROM between NUM_REQ render clients
//  (field renderer = req 0, next-piece preview = req 1, more slots spare).

---
 rtl/sprite_rom_arbiter.sv | 110 +++++++++++
 tb/tb_sprite_rom_arbiter.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/sprite_rom_arbiter.sv
// rtl/sprite_rom_arbiter.sv - round-robin pipelined arbiter sharing the block-sprite ROM
//
// Purpose: lets NUM_REQ render clients share one sprite ROM. Each cycle at most
// one client is granted (round-robin from ptr). The grant is issued to the ROM
// on the next cycle. The owner index travels in a tag pipeline alongside the
// ROM access, and the read data is returned to that owner with a registered
// rvalid. Cycles in which two or more clients request at once are counted.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   req[NUM_REQ]        per-client read request, held until grant
//   addr_x, addr_y      per-client sprite column/row, 4 bits per client
//   grant[NUM_REQ]      combinational one-hot accept
//   rvalid[NUM_REQ]     registered one-hot return strobe
//   rdata[12]           returned pixel, broadcast, holds when idle
//   rom_en, rom_addr    registered ROM read port, rom_addr = {y, x}
//   rom_data[12]        ROM read data, valid ROM_LATENCY after rom_en
//   conflict_cnt        saturating count of multi-request cycles
module sprite_rom_arbiter #(
    parameter int NUM_REQ     = 2,
    parameter int ROM_LATENCY = 1,
    parameter int CNT_W       = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req,
    input  logic [4*NUM_REQ-1:0] addr_x,
    input  logic [4*NUM_REQ-1:0] addr_y,
    output logic [NUM_REQ-1:0]   grant,
    output logic [NUM_REQ-1:0]   rvalid,
    output logic [11:0]          rdata,
    output logic                 rom_en,
    output logic [7:0]           rom_addr,
    input  logic [11:0]          rom_data,
    output logic [CNT_W-1:0]     conflict_cnt
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [IDX_W-1:0] ptr;
    logic [IDX_W-1:0] win_idx;
    logic             win_found;
    int               cand;

    // Tag stage s holds the owner of the ROM access issued s cycles earlier;
    // the last stage lines up with rom_data being valid.
    logic [ROM_LATENCY:0] tag_vld;
    logic [IDX_W-1:0]     tag_own [ROM_LATENCY:0];

    // Round-robin search starting at ptr. Reset suppresses the grant so that
    // nothing is accepted in a cycle that will also clear the pipeline.
    always_comb begin
        win_idx   = '0;
        win_found = 1'b0;
        cand      = 0;
        grant     = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = (int'(ptr) + k) % NUM_REQ;
            if (!win_found && req[cand]) begin
                win_found = 1'b1;
                win_idx   = IDX_W'(cand);
            end
        end
        if (rst) begin
            win_found = 1'b0;
        end
        if (win_found) begin
            grant[win_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr          <= '0;
            rom_en       <= 1'b0;
            rom_addr     <= '0;
            tag_vld      <= '0;
            for (int s = 0; s <= ROM_LATENCY; s++) begin
                tag_own[s] <= '0;
            end
            rvalid       <= '0;
            rdata        <= '0;
            conflict_cnt <= '0;
        end else begin
            if (win_found) begin
                ptr      <= (win_idx == IDX_W'(NUM_REQ - 1)) ? '0 : win_idx + IDX_W'(1);
                rom_addr <= {addr_y[4*win_idx +: 4], addr_x[4*win_idx +: 4]};
            end
            rom_en <= win_found;

            tag_vld[0] <= win_found;
            tag_own[0] <= win_idx;
            for (int s = 1; s <= ROM_LATENCY; s++) begin
                tag_vld[s] <= tag_vld[s-1];
                tag_own[s] <= tag_own[s-1];
            end

            rvalid <= '0;
            if (tag_vld[ROM_LATENCY]) begin
                rvalid[tag_own[ROM_LATENCY]] <= 1'b1;
                rdata                        <= rom_data;
            end

            if (($countones(req) >= 2) && (conflict_cnt != '1)) begin
                conflict_cnt <= conflict_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// tb/tb_sprite_rom_arbiter.sv - self-checking bench for sprite_rom_arbiter
module tb_sprite_rom_arbiter;

    localparam int N  = 2;
    localparam int L  = 1;
    localparam int CW = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  req;
    logic [7:0]  addr_x;
    logic [7:0]  addr_y;
    logic [1:0]  grant;
    logic [1:0]  rvalid;
    logic [11:0] rdata;
    logic        rom_en;
    logic [7:0]  rom_addr;
    logic [11:0] rom_data = 12'h000;
    logic [15:0] conflict_cnt;

    sprite_rom_arbiter #(.NUM_REQ(N), .ROM_LATENCY(L), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .req(req), .addr_x(addr_x), .addr_y(addr_y),
        .grant(grant), .rvalid(rvalid), .rdata(rdata), .rom_en(rom_en),
        .rom_addr(rom_addr), .rom_data(rom_data), .conflict_cnt(conflict_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [11:0] rom_fn(input logic [7:0] a);
        if (a == 8'h53) return 12'hABC;
        return {a, a[7:4]} ^ 12'h5A5;
    endfunction

    // Sprite ROM with one cycle of read latency.
    always @(posedge clk) begin
        if (rom_en) rom_data <= rom_fn(rom_addr);
    end

    typedef struct {
        int         owner;
        int         due;
        logic [7:0] a;
    } pend_t;

    pend_t       pq[$];
    int          m_ptr;
    int          cyc;
    logic        m_en;
    logic [7:0]  m_addr;
    logic [1:0]  m_rvalid;
    logic [11:0] m_rdata;
    int          m_cnt;
    int          n_vec;
    int          n_miss;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: check outputs mid-cycle, then advance the model.
    task automatic cycle();
        int    w;
        int    hits;
        pend_t e;
        @(negedge clk);
        w    = -1;
        hits = 0;
        for (int k = 0; k < N; k++) begin
            int i;
            i = (m_ptr + k) % N;
            if (req[i]) begin
                hits++;
                if (w < 0) w = i;
            end
        end
        chk("grant", grant, (rst || w < 0) ? 0 : (1 << w));
        chk("rom_en", rom_en, m_en);
        if (m_en) chk("rom_addr", rom_addr, m_addr);
        chk("rvalid", rvalid, m_rvalid);
        chk("rdata", rdata, m_rdata);
        chk("conflict_cnt", conflict_cnt, m_cnt);
        if (rst) begin
            m_ptr = 0; pq.delete(); m_en = 0; m_addr = 0;
            m_rvalid = 0; m_rdata = 0; m_cnt = 0;
        end else begin
            m_en = (w >= 0);
            if (w >= 0) begin
                m_addr  = {addr_y[4*w +: 4], addr_x[4*w +: 4]};
                e.owner = w;
                e.due   = cyc + 2 + L;
                e.a     = m_addr;
                pq.push_back(e);
                m_ptr   = (w + 1) % N;
            end
            m_rvalid = 0;
            if (pq.size() > 0 && pq[0].due == cyc + 1) begin
                m_rvalid = 2'(1 << pq[0].owner);
                m_rdata  = rom_fn(pq[0].a);
                void'(pq.pop_front());
            end
            if (hits >= 2 && m_cnt < (1 << CW) - 1) m_cnt++;
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_vec = 0; n_miss = 0; cyc = 0;
        m_ptr = 0; m_en = 0; m_addr = 0; m_rvalid = 0; m_rdata = 0; m_cnt = 0;
        rst = 1'b1; req = 2'b00; addr_x = 8'h00; addr_y = 8'h00;
        @(posedge clk);
        #1;
        cycle(); cycle();
        rst = 1'b0;

        // Single read of ROM[0x53]
        req = 2'b01; addr_x = 8'h03; addr_y = 8'h05;
        cycle();
        req = 2'b00;
        cycle(); cycle();
        chk("t1_rvalid", rvalid, 2'b01);
        chk("t1_rdata", rdata, 12'hABC);
        repeat (2) cycle();

        // Both clients held for 8 cycles
        rst = 1'b1; cycle(); rst = 1'b0;
        req = 2'b11; addr_x = 8'h7A; addr_y = 8'h2C;
        repeat (8) cycle();
        req = 2'b00;
        chk("t2_cnt", conflict_cnt, 16'd8);
        repeat (4) cycle();

        // Pointer after granting client 1 wraps to client 0
        rst = 1'b1; cycle(); rst = 1'b0;
        req = 2'b10; cycle();
        req = 2'b11; cycle();
        req = 2'b00; repeat (4) cycle();

        // Reset with reads in flight
        req = 2'b11; cycle(); cycle();
        rst = 1'b1; cycle();
        rst = 1'b0; req = 2'b00;
        repeat (9) cycle();
        req = 2'b11; cycle();
        req = 2'b00; repeat (4) cycle();

        // Client 0 withdraws while client 1 holds the pointer
        req = 2'b01; addr_x = 8'h41; addr_y = 8'h96; cycle();
        req = 2'b10; cycle();
        req = 2'b00; cycle(); cycle();
        chk("t6_rvalid", rvalid, 2'b10);
        repeat (3) cycle();

        // Random traffic with occasional reset
        repeat (3000) begin
            rst    = ($urandom_range(0, 63) == 0);
            req    = 2'($urandom);
            addr_x = 8'($urandom);
            addr_y = 8'($urandom);
            cycle();
        end
        rst = 1'b0;

        // Counter saturation
        rst = 1'b1; cycle(); rst = 1'b0;
        req = 2'b11;
        repeat ((1 << CW) + 5) cycle();
        chk("t5_cnt", conflict_cnt, 16'hFFFF);
        req = 2'b00;
        repeat (4) cycle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
